sie_regs: RTL and testbench

CPU-side register responder for the USB SIE. It decodes I/O accesses in the SIE window (SIE_BASE_ADDR + 12-bit offset) and implements the endpoint control/data registers plus the USB_ADDRESS, USB_TOKEN and USB_STATUS registers. It buffers packet bytes between the CPU and the SIE through per-endpoint FIFOs. It sits between the CPU I/O bus and the SIE packet engine.

---
 rtl/sie_regs_pkg.sv | 36 +++
 rtl/sie_regs_ep_fifo.sv | 60 ++++++
 rtl/sie_regs.sv | 231 +++++++++++++++++++++++
 tb/tb_sie_regs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sie_regs_pkg.sv
// sie_regs_pkg: shared definitions for the USB SIE register responder.
//   - Register offsets inside the SIE I/O window (12-bit offset).
//   - STATUS bit indices.
//   - token_t (latched SIE token) and out_state_e (OUT0 buffer state).
package sie_regs_pkg;

  localparam logic [11:0] ENDP0_CONTROL  = 12'h000;
  localparam logic [11:0] ENDP0_DATA     = 12'h002;
  localparam logic [11:0] ENDP1_CONTROL  = 12'h004;
  localparam logic [11:0] ENDP1_DATA     = 12'h006;
  localparam logic [11:0] ENDPO0_CONTROL = 12'h040;
  localparam logic [11:0] ENDPO0_DATA    = 12'h042;
  localparam logic [11:0] USB_ADDRESS    = 12'h100;
  localparam logic [11:0] USB_TOKEN      = 12'h102;
  localparam logic [11:0] USB_STATUS     = 12'h104;
  localparam logic [11:0] IRQ_ENABLE     = 12'h106;

  localparam int unsigned ST_IN_DONE0 = 0;
  localparam int unsigned ST_IN_DONE1 = 1;
  localparam int unsigned ST_OUT_RDY  = 2;
  localparam int unsigned ST_OVF      = 3;
  localparam int unsigned ST_UNF      = 4;
  localparam int unsigned ST_W        = 5;

  typedef struct packed {
    logic [3:0] pid;
    logic [3:0] ep;
  } token_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_RECV,
    OUT_FULL
  } out_state_e;

endpackage

// File: rtl/sie_regs_ep_fifo.sv
// ep_fifo: DEPTH x 8 endpoint byte FIFO.
//   push/push_data : write one byte (ignored when full)
//   pop            : drop head byte (ignored when empty)
//   flush          : empty the FIFO, pointers back to 0
//   rewind         : discard all unread bytes (write pointer back to read pointer)
//   head           : head byte, 0 when empty
//   count          : bytes held (0..DEPTH)
module ep_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          rewind,
  output logic [7:0]    head,
  output logic [AW:0]   count
);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        empty, full, do_push, do_pop;

  always_comb begin
    count   = wr_q - rd_q;
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = push_data;

    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    if (rewind) wr_d = rd_d;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/sie_regs.sv
// sie_regs: CPU-side register responder for the USB SIE.
//   CPU bus : io_addr/io_din/io_wr/io_rd in, io_dout out (1-cycle read latency,
//             held until the next read in the window).
//   SIE IN  : sie_in_ep selects EP0/EP1; sie_in_rd pops, sie_in_data is the head,
//             sie_in_ready = selected endpoint armed, sie_in_done = host ACK.
//   SIE OUT : sie_out_we/sie_out_data push into OUT0, sie_out_commit/abort end
//             the packet, sie_out_ready low while a packet awaits the CPU.
//   Misc    : sie_token_valid/sie_token latched into USB_TOKEN,
//             usb_address driven from USB_ADDRESS.
//   Build option SIE_REGS_IRQ_EN adds IRQ_ENABLE (0x106) and the irq output.
module sie_regs
  import sie_regs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter logic [15:0] BASE  = 16'h6000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_din,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [15:0] io_dout,
  input  logic        sie_in_ep,
  input  logic        sie_in_rd,
  output logic [7:0]  sie_in_data,
  output logic        sie_in_ready,
  input  logic        sie_in_done,
  input  logic        sie_out_we,
  input  logic [7:0]  sie_out_data,
  input  logic        sie_out_commit,
  input  logic        sie_out_abort,
  output logic        sie_out_ready,
  input  logic        sie_token_valid,
  input  logic [7:0]  sie_token,
`ifdef SIE_REGS_IRQ_EN
  output logic [6:0]  usb_address,
  output logic        irq
`else
  output logic [6:0]  usb_address
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic            hit, cpu_wr, cpu_rd, unused_din;
  logic [11:0]     off;

  logic [1:0]      armed_q, armed_d;
  logic [1:0]      ctrl_wr, data_wr, in_push, in_pop, in_flush, in_full, in_ovf, in_done;
  logic [AW:0]     in_count [2];
  logic [7:0]      in_head  [2];

  out_state_e      out_state_q, out_state_d;
  logic            out_ovr_q, out_ovr_d;
  logic            out_push, out_pop, out_flush, out_rewind, out_rel;
  logic            out_commit_ok, out_unf, out_empty, out_full;
  logic [AW:0]     out_count;
  logic [7:0]      out_head;

  logic [ST_W-1:0] status_q, status_d, st_set, st_clr;
  logic [6:0]      addr_q, addr_d;
  token_t          token_q, token_d;
  logic [15:0]     io_dout_q, io_dout_d, rdata;
`ifdef SIE_REGS_IRQ_EN
  logic [ST_W-1:0] irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
`endif

  always_comb begin
    hit        = (io_addr[15:12] == BASE[15:12]);
    off        = io_addr[11:0];
    cpu_wr     = io_wr && hit;
    cpu_rd     = io_rd && hit;
    unused_din = ^io_din[15:8];
  end

  // IN endpoints: CPU fills while unarmed, SIE drains once armed.
  always_comb begin
    armed_d = armed_q;
    for (int unsigned n = 0; n < 2; n++) begin
      ctrl_wr[n]  = cpu_wr && (off == ((n == 0) ? ENDP0_CONTROL : ENDP1_CONTROL));
      data_wr[n]  = cpu_wr && (off == ((n == 0) ? ENDP0_DATA : ENDP1_DATA));
      in_done[n]  = sie_in_done && (sie_in_ep == 1'(n));
      in_pop[n]   = sie_in_rd && (sie_in_ep == 1'(n));
      in_full[n]  = (in_count[n] == CNT_FULL);
      in_push[n]  = data_wr[n] && !armed_q[n];
      in_ovf[n]   = data_wr[n] && in_full[n];
      in_flush[n] = in_done[n] || (ctrl_wr[n] && io_din[1]);
      if (ctrl_wr[n] && io_din[0]) armed_d[n] = 1'b1;
      if (in_flush[n])             armed_d[n] = 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_in
    ep_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .push      (in_push[g]),
      .push_data (io_din[7:0]),
      .pop       (in_pop[g]),
      .flush     (in_flush[g]),
      .rewind    (1'b0),
      .head      (in_head[g]),
      .count     (in_count[g])
    );
  end

  // OUT0: an overrun is remembered during RECV so the commit degrades to an abort.
  always_comb begin
    out_state_d   = out_state_q;
    out_ovr_d     = out_ovr_q;
    out_rewind    = 1'b0;
    out_commit_ok = 1'b0;
    out_empty     = (out_count == '0);
    out_full      = (out_count == CNT_FULL);
    out_push      = sie_out_we && (out_state_q != OUT_FULL);
    if (out_push && out_full) out_ovr_d = 1'b1;
    case (out_state_q)
      OUT_IDLE: if (sie_out_we) out_state_d = OUT_RECV;
      OUT_RECV: begin
        if (sie_out_abort || (sie_out_commit && out_ovr_d)) begin
          out_state_d = OUT_IDLE;
          out_rewind  = 1'b1;
          out_ovr_d   = 1'b0;
        end else if (sie_out_commit) begin
          out_state_d   = OUT_FULL;
          out_commit_ok = 1'b1;
        end
      end
      default: ;
    endcase
    out_rel   = cpu_wr && (off == ENDPO0_CONTROL) && io_din[0];
    out_flush = out_rel;
    if (out_rel) begin
      out_state_d = OUT_IDLE;
      out_ovr_d   = 1'b0;
    end
    out_pop = cpu_rd && (off == ENDPO0_DATA);
    out_unf = out_pop && out_empty;
  end

  ep_fifo #(.DEPTH(DEPTH)) u_out0 (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (out_push),
    .push_data (sie_out_data),
    .pop       (out_pop),
    .flush     (out_flush),
    .rewind    (out_rewind),
    .head      (out_head),
    .count     (out_count)
  );

  // Registers, status and read mux.
  always_comb begin
    st_set              = '0;
    st_set[ST_IN_DONE0] = in_done[0];
    st_set[ST_IN_DONE1] = in_done[1];
    st_set[ST_OUT_RDY]  = out_commit_ok;
    st_set[ST_OVF]      = |in_ovf;
    st_set[ST_UNF]      = out_unf;
    st_clr   = (cpu_wr && (off == USB_STATUS)) ? io_din[ST_W-1:0] : '0;
    status_d = (status_q & ~st_clr) | st_set;

    addr_d  = (cpu_wr && (off == USB_ADDRESS)) ? io_din[6:0] : addr_q;
    token_d = sie_token_valid ? token_t'(sie_token) : token_q;

    rdata = '0;
    case (off)
      ENDP0_CONTROL:  begin rdata = 16'(in_count[0]); rdata[15] = armed_q[0]; end
      ENDP1_CONTROL:  begin rdata = 16'(in_count[1]); rdata[15] = armed_q[1]; end
      ENDPO0_CONTROL: begin rdata = 16'(out_count); rdata[15] = (out_state_q == OUT_FULL); end
      ENDPO0_DATA:    rdata = {8'h00, out_head};
      USB_ADDRESS:    rdata = {9'h000, addr_q};
      USB_TOKEN:      rdata = {8'h00, token_q};
      USB_STATUS:     rdata = 16'(status_q);
`ifdef SIE_REGS_IRQ_EN
      IRQ_ENABLE:     rdata = 16'(irq_en_q);
`endif
      default:        rdata = '0;
    endcase
    io_dout_d = cpu_rd ? rdata : io_dout_q;

`ifdef SIE_REGS_IRQ_EN
    irq_en_d = (cpu_wr && (off == IRQ_ENABLE)) ? io_din[ST_W-1:0] : irq_en_q;
    irq_d    = |(status_q & irq_en_q);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q     <= '0;
      out_state_q <= OUT_IDLE;
      out_ovr_q   <= 1'b0;
      status_q    <= '0;
      addr_q      <= '0;
      token_q     <= '0;
      io_dout_q   <= '0;
`ifdef SIE_REGS_IRQ_EN
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      armed_q     <= armed_d;
      out_state_q <= out_state_d;
      out_ovr_q   <= out_ovr_d;
      status_q    <= status_d;
      addr_q      <= addr_d;
      token_q     <= token_d;
      io_dout_q   <= io_dout_d;
`ifdef SIE_REGS_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
`endif
    end
  end

  always_comb begin
    io_dout       = io_dout_q;
    usb_address   = addr_q;
    sie_in_data   = in_head[sie_in_ep];
    sie_in_ready  = armed_q[sie_in_ep];
    sie_out_ready = (out_state_q != OUT_FULL);
`ifdef SIE_REGS_IRQ_EN
    irq           = irq_q;
`endif
  end

endmodule

// File: tb/tb_sie_regs.sv
// tb_sie_regs: directed self-checking bench for sie_regs (DEPTH=8, BASE=16'h6000).
module tb_sie_regs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] io_addr, io_din, io_dout;
  logic        io_wr, io_rd;
  logic        sie_in_ep, sie_in_rd, sie_in_ready, sie_in_done;
  logic [7:0]  sie_in_data;
  logic        sie_out_we, sie_out_commit, sie_out_abort, sie_out_ready;
  logic [7:0]  sie_out_data;
  logic        sie_token_valid;
  logic [7:0]  sie_token;
  logic [6:0]  usb_address;
`ifdef SIE_REGS_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] rd_val;

  sie_regs #(.DEPTH(8), .BASE(16'h6000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .io_addr         (io_addr),
    .io_din          (io_din),
    .io_wr           (io_wr),
    .io_rd           (io_rd),
    .io_dout         (io_dout),
    .sie_in_ep       (sie_in_ep),
    .sie_in_rd       (sie_in_rd),
    .sie_in_data     (sie_in_data),
    .sie_in_ready    (sie_in_ready),
    .sie_in_done     (sie_in_done),
    .sie_out_we      (sie_out_we),
    .sie_out_data    (sie_out_data),
    .sie_out_commit  (sie_out_commit),
    .sie_out_abort   (sie_out_abort),
    .sie_out_ready   (sie_out_ready),
    .sie_token_valid (sie_token_valid),
    .sie_token       (sie_token),
`ifdef SIE_REGS_IRQ_EN
    .usb_address     (usb_address),
    .irq             (irq)
`else
    .usb_address     (usb_address)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_din = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_dout;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    cpu_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic sie_pop(input logic ep, input logic [7:0] exp, input string tag);
    @(negedge clk);
    sie_in_ep = ep;
    #1;
    check(tag, 16'(sie_in_data), 16'(exp));
    sie_in_rd = 1'b1;
    @(negedge clk);
    sie_in_rd = 1'b0;
  endtask

  task automatic sie_push(input logic [7:0] b);
    @(negedge clk);
    sie_out_we = 1'b1; sie_out_data = b;
    @(negedge clk);
    sie_out_we = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk); sie_out_commit = 1'b1;
    @(negedge clk); sie_out_commit = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); sie_out_abort = 1'b1;
    @(negedge clk); sie_out_abort = 1'b0;
  endtask

  task automatic pulse_done(input logic ep);
    @(negedge clk); sie_in_ep = ep; sie_in_done = 1'b1;
    @(negedge clk); sie_in_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    io_addr = '0; io_din = '0; io_wr = 1'b0; io_rd = 1'b0;
    sie_in_ep = 1'b0; sie_in_rd = 1'b0; sie_in_done = 1'b0;
    sie_out_we = 1'b0; sie_out_data = '0; sie_out_commit = 1'b0; sie_out_abort = 1'b0;
    sie_token_valid = 1'b0; sie_token = '0;

    #3;
    check("rst_io_dout", io_dout, 16'h0000);
    check("rst_usb_address", 16'(usb_address), 16'h0000);
    check("rst_in_ready", 16'(sie_in_ready), 16'h0000);
    check("rst_out_ready", 16'(sie_out_ready), 16'h0001);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // EP0: fill, arm, SIE drains in order
    cpu_write(16'h6002, 16'h0011);
    cpu_write(16'h6002, 16'h0022);
    cpu_write(16'h6002, 16'h0033);
    cpu_write(16'h6000, 16'h0001);
    read_check("ep0_ctrl_armed", 16'h6000, 16'h8003);
    sie_in_ep = 1'b0; #1;
    check("ep0_in_ready", 16'(sie_in_ready), 16'h0001);
    sie_pop(1'b0, 8'h11, "ep0_pop0");
    sie_pop(1'b0, 8'h22, "ep0_pop1");
    sie_pop(1'b0, 8'h33, "ep0_pop2");
    sie_pop(1'b0, 8'h00, "ep0_empty_data");
    read_check("ep0_ctrl_drained", 16'h6000, 16'h8000);
    pulse_done(1'b0);
    read_check("status_done0", 16'h6104, 16'h0001);
    cpu_write(16'h6104, 16'h0001);

    // EP1 done
    cpu_write(16'h6006, 16'h0055);
    cpu_write(16'h6004, 16'h0001);
    read_check("ep1_ctrl_armed", 16'h6004, 16'h8001);
    pulse_done(1'b1);
    read_check("ep1_ctrl_after_done", 16'h6004, 16'h0000);
    read_check("status_done1", 16'h6104, 16'h0002);
    cpu_write(16'h6104, 16'h0002);
    read_check("status_w1c", 16'h6104, 16'h0000);

    // EP1 overflow: 9 pushes, 8 kept
    for (int i = 0; i < 9; i++) cpu_write(16'h6006, 16'(8'h40 + i));
    read_check("ep1_count_full", 16'h6004, 16'h0008);
    read_check("status_ovf", 16'h6104, 16'h0008);
    cpu_write(16'h6004, 16'h0001);
    for (int i = 0; i < 8; i++) sie_pop(1'b1, 8'(8'h40 + i), "ep1_pop");
    sie_pop(1'b1, 8'h00, "ep1_pop_empty");
    read_check("ep1_count_after_drain", 16'h6004, 16'h8000);
    cpu_write(16'h6004, 16'h0002);
    read_check("ep1_flushed", 16'h6004, 16'h0000);
    cpu_write(16'h6104, 16'h0008);

    // OUT0 good packet
    sie_push(8'hA5);
    sie_push(8'h5A);
    pulse_commit();
    check("out_ready_full", 16'(sie_out_ready), 16'h0000);
    read_check("out_ctrl_full", 16'h6040, 16'h8002);
    read_check("status_out_rdy", 16'h6104, 16'h0004);
    read_check("out_data0", 16'h6042, 16'h00A5);
    read_check("out_data1", 16'h6042, 16'h005A);
    read_check("out_data_unf", 16'h6042, 16'h0000);
    read_check("status_unf", 16'h6104, 16'h0014);
    cpu_write(16'h6104, 16'h001F);
    cpu_write(16'h6040, 16'h0001);
    check("out_ready_released", 16'(sie_out_ready), 16'h0001);
    read_check("out_ctrl_released", 16'h6040, 16'h0000);

    // OUT0 abort and overrun
    sie_push(8'h01); sie_push(8'h02); sie_push(8'h03);
    read_check("out_ctrl_recv", 16'h6040, 16'h0003);
    pulse_abort();
    read_check("out_ctrl_abort", 16'h6040, 16'h0000);
    check("out_ready_abort", 16'(sie_out_ready), 16'h0001);
    for (int i = 0; i < 9; i++) sie_push(8'(i));
    pulse_commit();
    check("out_ready_overrun", 16'(sie_out_ready), 16'h0001);
    read_check("out_ctrl_overrun", 16'h6040, 16'h0000);
    read_check("status_overrun", 16'h6104, 16'h0000);

    // Simultaneous CPU push and SIE pop on EP0
    cpu_write(16'h6002, 16'h0077);
    @(negedge clk);
    io_addr = 16'h6002; io_din = 16'h0088; io_wr = 1'b1;
    sie_in_ep = 1'b0; sie_in_rd = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; sie_in_rd = 1'b0;
    #1;
    check("ep0_concurrent_head", 16'(sie_in_data), 16'h0088);
    read_check("ep0_concurrent_count", 16'h6000, 16'h0001);

    // Address, token, decode, read hold
    cpu_write(16'h6100, 16'h002A);
    check("usb_address", 16'(usb_address), 16'h002A);
    read_check("usb_address_rd", 16'h6100, 16'h002A);
    cpu_write(16'h7100, 16'h0055);
    check("usb_address_outside", 16'(usb_address), 16'h002A);
    cpu_write(16'h6108, 16'hFFFF);
    read_check("unmapped_rd", 16'h6200, 16'h0000);
    read_check("irq_en_or_unmapped", 16'h6106, 16'h0000);
    @(negedge clk); sie_token = 8'h90; sie_token_valid = 1'b1;
    @(negedge clk); sie_token_valid = 1'b0; sie_token = 8'hFF;
    read_check("token_rd", 16'h6102, 16'h0090);
    cpu_read(16'h7102, rd_val);
    repeat (3) @(negedge clk);
    check("dout_hold", io_dout, 16'h0090);

    // Reset in the middle of an OUT packet with EP0 armed
    cpu_write(16'h6000, 16'h0001);
    #1;
    check("pre_reset_in_ready", 16'(sie_in_ready), 16'h0001);
    sie_push(8'hC3);
    sie_push(8'h3C);
    read_check("pre_reset_out_recv", 16'h6040, 16'h0002);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_io_dout", io_dout, 16'h0000);
    check("mid_rst_usb_address", 16'(usb_address), 16'h0000);
    check("mid_rst_in_ready", 16'(sie_in_ready), 16'h0000);
    check("mid_rst_in_data", 16'(sie_in_data), 16'h0000);
    check("mid_rst_out_ready", 16'(sie_out_ready), 16'h0001);
    @(negedge clk);
    reset_n = 1'b1;
    read_check("post_rst_out_ctrl", 16'h6040, 16'h0000);
    read_check("post_rst_ep0_ctrl", 16'h6000, 16'h0000);
    read_check("post_rst_token", 16'h6102, 16'h0000);
    read_check("post_rst_status", 16'h6104, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
